dram_refill_arbiter: RTL

//  Shares the single DRAM port between NUM_REQ cache miss-repair requesters (req 0 = I-cache, req 1 = D-cache).

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/dram_refill_arbiter_rr_pick.sv | 32 +++
 rtl/dram_refill_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the DRAM refill arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dram_refill_arbiter_rr_pick.sv
// Round-robin picker: first requester with req=1 searching upward from rr_ptr, with wrap.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ),
    localparam int unsigned SUM_W  = IDX_W + 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [SUM_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            // rr_ptr + off stays below 2*NUM_REQ, so one subtraction wraps it
            cand = SUM_W'(rr_ptr) + SUM_W'(off);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dram_refill_arbiter.sv
// Round-robin arbiter sharing one DRAM port between cache miss-repair requesters.
// Optional DRAM wait timeout enabled by defining ARB_TIMEOUT_EN.
module dram_refill_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      dram_req,
    output logic [ADDR_W-1:0]         dram_addr,
    output logic                      dram_we,
    output logic [DATA_W-1:0]         dram_wdata,
    input  logic                      dram_ready,
    input  logic [DATA_W-1:0]         dram_rdata,
    output logic                      busy,
    output logic [IDX_W-1:0]          gnt_id,
    output logic                      timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("dram_refill_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dram_refill_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [DATA_W-1:0] rdata_q;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Single FSM: grant in IDLE, hold DRAM request in WAIT, pulse completion leaving RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            rdata_q    <= '0;
            req_ready  <= '0;
            req_rdata  <= '0;
            dram_req   <= 1'b0;
            dram_addr  <= '0;
            dram_we    <= 1'b0;
            dram_wdata <= '0;
            busy       <= 1'b0;
            gnt_id     <= '0;
`ifdef ARB_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_q   <= 1'b0;
            timeout_err <= 1'b0;
`endif
        end else begin
            req_ready <= '0;
            req_rdata <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        dram_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        dram_we    <= req_we[pick_idx];
                        dram_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
                        gnt_id     <= pick_idx;
                        dram_req   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= WAIT;
`ifdef ARB_TIMEOUT_EN
                        wait_cnt  <= '0;
                        timeout_q <= 1'b0;
`endif
                    end
                end
                WAIT: begin
                    if (dram_ready) begin
                        rdata_q  <= dram_rdata;
                        dram_req <= 1'b0;
                        state    <= RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rdata_q     <= '0;
                        timeout_q   <= 1'b1;
                        timeout_err <= 1'b1;
                        dram_req    <= 1'b0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    req_ready[gnt_id] <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                    req_rdata <= (dram_we || timeout_q) ? '0 : rdata_q;
`else
                    req_rdata <= dram_we ? '0 : rdata_q;
`endif
                    rr_ptr <= (gnt_id == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id + IDX_W'(1);
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    dram_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
